fma_norm_round: RTL and testbench
=================================

Name: fma_norm_round

Overview:
- Post-add stage of the fp16 FMA datapath; consumes the unnormalized sum mantissa, exponent and sign from the add stage.
- Leading-zero counts and normalizes the 36-bit sum, rounds to binary16 under a selectable rounding mode, and raises status flags.
- Multi-cycle FSM with valid/ready handshakes on both sides; one operation in flight at a time.

Parameters:
- SM_W, 36, sum mantissa width
- NORM_POS, 22, bit of sm whose weight is 2^(se-EXP_BIAS)
- EXP_BIAS, 15, binary16 exponent bias

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream operands valid
- in_ready  out  1  block can accept; high only in IDLE
- sm  in  SM_W  unsigned sum magnitude
- se  in  7  signed two's-complement exponent of bit NORM_POS
- ss  in  1  result sign
- sticky_in  in  1  OR of addend bits shifted out upstream
- roundmode  in  2  00 RZ, 01 RNE, 10 RM (toward -inf), 11 RP (toward +inf)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts
- result  out  16  binary16 result
- flags  out  3  {overflow, underflow, inexact}

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, result=16'h0000, flags=3'b000. Reset mid-operation discards the operation.
- States:
  - IDLE: on in_valid&in_ready, capture all inputs -> LZC.
  - LZC: lzc = leading-zero count of sm; lead = SM_W-1-lzc; E = se + lead - NORM_POS (9-bit signed) -> NORM.
  - NORM: left-shift sm so lead lands at the MSB. mant = next 10 bits, guard = following bit, sticky = OR(remaining bits) | sticky_in -> RND.
  - RND: apply rounding, pack result, set flags -> OUT.
  - OUT: out_valid=1; result and flags held stable until out_ready. On out_ready -> IDLE.
- Latency: 4 cycles from accept to out_valid. Throughput: one operation per 5 cycles, more under backpressure.
- Rounding increment:
  - RZ: 0.
  - RNE: guard & (sticky | mant[0]).
  - RM: ss & (guard|sticky).
  - RP: ~ss & (guard|sticky).
- Mantissa carry-out from 0x3FF: mant=0, E+1.
- inexact = guard|sticky.
- Overflow (E>=31 after rounding): overflow=1, inexact=1.
  - RNE: ±inf (0x7C00/0xFC00).
  - RZ: ±0x7BFF.
  - RM: -inf if ss, else 0x7BFF.
  - RP: +inf if ~ss, else 0xFBFF.
- Underflow (E<=0), default build: flush to signed zero; underflow=1, inexact=1.
- sm==0 and sticky_in==0: exact zero. Sign = 1 only when roundmode=RM; flags=0.
- sm==0 and sticky_in==1: treated as underflow.
- No NaN/inf inputs; special cases are handled in a separate bypass.

Optional Feature:
- FMA_NORM_SUBNORM_EN defined:
  - E<=0 produces gradual underflow: right-shift by (1-E), collapsing shifted-out bits into sticky, then round normally.
  - Exponent field 0, or 1 if rounding carries into the hidden bit.
  - underflow=1 only when the result is tiny and inexact.
- Not defined: flush-to-zero as above.

Decomposition:
- Package fma16_pkg holds:
  - roundmode_t enum (RZ, RNE, RM, RP);
  - norm_state_t enum (IDLE, LZC, NORM, RND, OUT);
  - constants EXP_BIAS, NORM_POS, FP16_INF=16'h7C00, FP16_MAXN=16'h7BFF.
- One sub-module, fma_lzc36: combinational 36-bit leading-zero counter, output 6 bits, 36 when input is zero.

Test Plan:
- sm=36'h000400000, se=15, ss=0, RNE -> result 16'h3C00, flags 000, out_valid exactly 4 cycles after accept.
- sm=36'h000400800 (guard tie), se=15: RNE -> 16'h3C00, inexact=1; RP -> 16'h3C01; RM with ss=1 -> 16'hBC01.
- sm=36'h000800000, se=30: RNE -> 16'h7C00, flags 101; RZ -> 16'h7BFF, flags 101.
- sm=36'h000000001, se=15:
  - default build -> 16'h0000, flags 011;
  - FMA_NORM_SUBNORM_EN -> 16'h0004, flags 000.
- sm=0, sticky_in=0: RNE -> 16'h0000; RM -> 16'h8000; flags 000.
- Hold out_ready=0 for 10 cycles: result stable and in_ready=0 throughout. Pulse reset during NORM: next cycle out_valid=0, in_ready=1, and the discarded operation never appears.

Source files
------------

// File: rtl/fma16_pkg.sv
// ============================================================================
// Module      : fma16_pkg
// Description : Shared types and binary16 constants for the fp16 FMA datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fma16_pkg;

   typedef enum logic [1:0] {
      RZ  = 2'b00,
      RNE = 2'b01,
      RM  = 2'b10,
      RP  = 2'b11
   } roundmode_t;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LZC  = 3'd1,
      NORM = 3'd2,
      RND  = 3'd3,
      OUT  = 3'd4
   } norm_state_t;

   localparam int          EXP_BIAS  = 15;
   localparam int          NORM_POS  = 22;
   localparam logic [15:0] FP16_INF  = 16'h7C00;
   localparam logic [15:0] FP16_MAXN = 16'h7BFF;

endpackage

`default_nettype wire

// File: rtl/fma_lzc36.sv
// ============================================================================
// Module      : fma_lzc36
// Description : Combinational 36-bit leading-zero counter; returns 36 for zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fma_lzc36 (
   input  logic [35:0] i_din,
   output logic [5:0]  o_lzc
);

   // Scanning upward lets the highest set bit win the last assignment.
   always_comb begin
      o_lzc = 6'd36;
      for (int i = 0; i < 36; i++) begin
         if (i_din[i]) begin
            o_lzc = 6'(35 - i);
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/fma_norm_round.sv
// ============================================================================
// Module      : fma_norm_round
// Description : fp16 FMA post-add stage: LZC, normalize, round, flag.
//               Define FMA_NORM_SUBNORM_EN for gradual underflow.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fma_norm_round #(
   parameter int SM_W     = 36,
   parameter int NORM_POS = fma16_pkg::NORM_POS,
   parameter int EXP_BIAS = fma16_pkg::EXP_BIAS
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [SM_W-1:0] sm,
   input  logic [6:0]      se,
   input  logic            ss,
   input  logic            sticky_in,
   input  logic [1:0]      roundmode,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [15:0]     result,
   output logic [2:0]      flags
);

   import fma16_pkg::*;

   localparam logic signed [8:0] c_EXP_MAX = 9'(2 * EXP_BIAS + 1);

   norm_state_t       r_state;
   norm_state_t       w_state_nxt;

   logic [SM_W-1:0]   r_sm;
   logic [6:0]        r_se;
   logic              r_ss;
   logic              r_sticky_in;
   roundmode_t        r_rm;
   logic [5:0]        r_lzc;
   logic signed [8:0] r_exp;
   logic              r_zero;
   logic [9:0]        r_mant;
   logic              r_guard;
   logic              r_sticky;
   logic [15:0]       r_result;
   logic [2:0]        r_flags;

   logic [5:0]        w_lzc;
   logic [8:0]        w_exp;
   logic [SM_W-2:0]   w_norm;
   logic              w_tiny;
   logic [9:0]        w_mant;
   logic              w_guard;
   logic              w_stk;
   logic [8:0]        w_efield;
   logic              w_inexact;
   logic              w_inc;
   logic [18:0]       w_sum;
   logic signed [8:0] w_exp_rnd;
   logic              w_ovf_inf;
   logic [15:0]       w_result;
   logic [2:0]        w_flags;
`ifdef FMA_NORM_SUBNORM_EN
   logic signed [8:0] w_sh;
   logic [3:0]        w_shc;
   logic [23:0]       w_den;
`endif

   fma_lzc36 u_lzc (
      .i_din (r_sm),
      .o_lzc (w_lzc)
   );

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (in_valid) w_state_nxt = LZC;
         LZC:     w_state_nxt = NORM;
         NORM:    w_state_nxt = RND;
         RND:     w_state_nxt = OUT;
         OUT:     if (out_ready) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (r_state == IDLE);
      out_valid = (r_state == OUT);
   end

   assign result = r_result;
   assign flags  = r_flags;

   // ----------------------------------------------------------- datapath
   // Biased exponent of the leading one: se + (SM_W-1-lzc) - NORM_POS.
   assign w_exp  = 9'({{2{r_se[6]}}, r_se}) + 9'(SM_W - 1 - NORM_POS) - {3'b000, r_lzc};
   // The leading one is shifted out the top; what remains is the fraction.
   assign w_norm = (SM_W-1)'(r_sm << r_lzc);
   assign w_tiny = r_zero | (r_exp < 9'sd1);

   always_comb begin
      w_mant   = r_mant;
      w_guard  = r_guard;
      w_stk    = r_sticky;
      w_efield = r_exp;
`ifdef FMA_NORM_SUBNORM_EN
      w_sh  = 9'sd1 - r_exp;
      w_shc = (r_zero || (w_sh > 9'sd13)) ? 4'd13 : w_sh[3:0];
      w_den = 24'({1'b1, r_mant, r_guard, 13'b0} >> w_shc);
      if (w_tiny) begin
         w_mant   = w_den[23:14];
         w_guard  = w_den[13];
         w_stk    = r_sticky | (|w_den[12:0]);
         w_efield = '0;
      end
`endif
      w_inexact = w_guard | w_stk;
      case (r_rm)
         RNE:     w_inc = w_guard & (w_stk | w_mant[0]);
         RM:      w_inc = r_ss & w_inexact;
         RP:      w_inc = ~r_ss & w_inexact;
         default: w_inc = 1'b0;
      endcase
      // Carry from an all-ones mantissa ripples straight into the exponent.
      w_sum     = {w_efield, w_mant} + 19'(w_inc);
      w_exp_rnd = w_sum[18:10];
      w_ovf_inf = (r_rm == RNE) | ((r_rm == RM) & r_ss) | ((r_rm == RP) & ~r_ss);

      w_result = {r_ss, w_sum[14:0]};
      w_flags  = {1'b0, w_tiny & w_inexact, w_inexact};
      if (r_zero && !r_sticky_in) begin
         w_result = {(r_rm == RM), 15'b0};
         w_flags  = 3'b000;
      end
`ifndef FMA_NORM_SUBNORM_EN
      else if (w_tiny) begin
         w_result = {r_ss, 15'b0};
         w_flags  = 3'b011;
      end
`endif
      else if (w_exp_rnd >= c_EXP_MAX) begin
         w_result = (w_ovf_inf ? FP16_INF : FP16_MAXN) | {r_ss, 15'b0};
         w_flags  = 3'b101;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sm        <= '0;
         r_se        <= '0;
         r_ss        <= 1'b0;
         r_sticky_in <= 1'b0;
         r_rm        <= RZ;
         r_lzc       <= '0;
         r_exp       <= '0;
         r_zero      <= 1'b0;
         r_mant      <= '0;
         r_guard     <= 1'b0;
         r_sticky    <= 1'b0;
         r_result    <= '0;
         r_flags     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_sm        <= sm;
                  r_se        <= se;
                  r_ss        <= ss;
                  r_sticky_in <= sticky_in;
                  r_rm        <= roundmode_t'(roundmode);
               end
            end
            LZC: begin
               r_lzc  <= w_lzc;
               r_zero <= ~|r_sm;
            end
            NORM: begin
               r_exp    <= w_exp;
               r_mant   <= w_norm[SM_W-2 -: 10];
               r_guard  <= w_norm[SM_W-12];
               r_sticky <= (|w_norm[SM_W-13:0]) | r_sticky_in;
            end
            RND: begin
               r_result <= w_result;
               r_flags  <= w_flags;
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fma_norm_round.sv
// ============================================================================
// Module      : tb_fma_norm_round
// Description : Self-checking bench for fma_norm_round against an arithmetic
//               reference model; honours FMA_NORM_SUBNORM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fma_norm_round;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [35:0] sm = '0;
   logic [6:0]  se = '0;
   logic        ss = 1'b0;
   logic        sticky_in = 1'b0;
   logic [1:0]  roundmode = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [15:0] result;
   logic [2:0]  flags;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   typedef struct {
      logic [15:0] res;
      logic [2:0]  fl;
      int          acc;
      bit          seen;
   } exp_t;
   exp_t expq[$];

   typedef struct {
      logic [35:0] m;
      logic [6:0]  e;
      logic        s;
      logic        st;
      logic [1:0]  rm;
      logic [18:0] want;
      int          stall;
   } vec_t;
   vec_t vt[12];

   fma_norm_round dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sm        (sm),
      .se        (se),
      .ss        (ss),
      .sticky_in (sticky_in),
      .roundmode (roundmode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .flags     (flags)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
      tests++;
      if (act !== want) begin
         fails++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, want, $time);
      end
   endtask

   // Value = m * 2^(e-15-22); returns {overflow, underflow, inexact, result}.
   function automatic logic [18:0] model(input logic [35:0] m, input int e, input logic s,
                                         input logic sti, input logic [1:0] rm);
      int     lead, ee, sh;
      longint q, r, half, enc;
      bit     g, st, up, tiny;
      logic [15:0] ov;
      if (m == 0 && !sti) return {3'b000, (rm == 2'b10), 15'h0};
      tiny = 1; ee = 0; q = 0; g = 0; st = 1;
      if (m != 0) begin
         lead = 0;
         for (int i = 0; i < 36; i++) if (m[i]) lead = i;
         ee   = e + lead - 22;
         tiny = (ee <= 0);
         sh   = lead - 10 + (tiny ? 1 - ee : 0);
         if (sh <= 0) begin
            q = longint'(m) << (-sh); g = 0; st = sti;
         end else if (sh > 40) begin
            q = 0; g = 0; st = 1;
         end else begin
            q    = longint'(m) >> sh;
            r    = longint'(m) - (q << sh);
            half = longint'(1) << (sh - 1);
            g    = (r >= half);
            st   = ((r % half) != 0) || sti;
         end
      end
`ifndef FMA_NORM_SUBNORM_EN
      if (tiny) return {3'b011, s, 15'h0};
`endif
      case (rm)
         2'b00:   up = 0;
         2'b01:   up = g && (st || q[0]);
         2'b10:   up = s && (g || st);
         default: up = !s && (g || st);
      endcase
      enc = tiny ? q + up : longint'(ee - 1) * 1024 + q + up;
      if (enc >= 31 * 1024) begin
         case (rm)
            2'b00:   ov = {s, 15'h7BFF};
            2'b01:   ov = {s, 15'h7C00};
            2'b10:   ov = s ? 16'hFC00 : 16'h7BFF;
            default: ov = s ? 16'hFBFF : 16'h7C00;
         endcase
         return {3'b101, ov};
      end
      return {1'b0, tiny && (g || st), g || st, s, 15'(enc)};
   endfunction

   // Compare process: every cycle the output is presented.
   always @(negedge clk) begin
      if (!reset && out_valid) begin
         if (expq.size() == 0) begin
            chk("spurious_out_valid", 32'(out_valid), 32'd0);
         end else begin
            if (!expq[0].seen) begin
               chk("latency_cycle", cyc, expq[0].acc + 3);
               expq[0].seen = 1;
            end
            chk("result", 32'(result), 32'(expq[0].res));
            chk("flags", 32'(flags), 32'(expq[0].fl));
            chk("in_ready_while_busy", 32'(in_ready), 32'd0);
            if (out_ready) void'(expq.pop_front());
         end
      end
   end

   task automatic do_op(input logic [35:0] a_m, input logic [6:0] a_e, input logic a_s,
                        input logic a_st, input logic [1:0] a_rm, input int stall,
                        input bit use_lit, input logic [18:0] lit);
      logic [18:0] w;
      exp_t        ent;
      int          n;
      w = use_lit ? lit : model(a_m, int'($signed(a_e)), a_s, a_st, a_rm);
      @(posedge clk); #1;
      sm = a_m; se = a_e; ss = a_s; sticky_in = a_st; roundmode = a_rm;
      in_valid  = 1'b1;
      out_ready = (stall == 0);
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 20) begin @(negedge clk); n++; end
      if (!in_ready) begin
         chk("accept_timeout", 32'(in_ready), 32'd1);
         in_valid = 1'b0;
         return;
      end
      ent = '{res: w[15:0], fl: w[18:16], acc: cyc + 1, seen: 0};
      expq.push_back(ent);
      @(posedge clk); #1;
      in_valid = 1'b0;
      sm = {$urandom, $urandom}; se = 7'($urandom); ss = 1'($urandom);
      sticky_in = 1'($urandom); roundmode = 2'($urandom);
      if (stall > 1) repeat (stall - 1) @(posedge clk);
      #1 out_ready = 1'b1;
      n = 0;
      while (expq.size() != 0 && n < 40) begin @(negedge clk); n++; end
      if (expq.size() != 0) begin
         chk("completion_timeout", expq.size(), 32'd0);
         expq.delete();
      end
   endtask

   initial begin
      int          w, ee;
      logic [35:0] one, mm;
      one = 36'h1;

      vt[0]  = '{36'h000400000, 7'd15, 0, 0, 2'b01, {3'b000, 16'h3C00}, 0};
      vt[1]  = '{36'h000400800, 7'd15, 0, 0, 2'b01, {3'b001, 16'h3C00}, 0};
      vt[2]  = '{36'h000400800, 7'd15, 0, 0, 2'b11, {3'b001, 16'h3C01}, 1};
      vt[3]  = '{36'h000400800, 7'd15, 1, 0, 2'b10, {3'b001, 16'hBC01}, 2};
      vt[4]  = '{36'h000800000, 7'd30, 0, 0, 2'b01, {3'b101, 16'h7C00}, 13};
      vt[5]  = '{36'h000800000, 7'd30, 0, 0, 2'b00, {3'b101, 16'h7BFF}, 0};
      vt[6]  = '{36'h000800000, 7'd30, 0, 0, 2'b10, {3'b101, 16'h7BFF}, 0};
      vt[7]  = '{36'h000800000, 7'd30, 1, 0, 2'b11, {3'b101, 16'hFBFF}, 0};
`ifdef FMA_NORM_SUBNORM_EN
      vt[8]  = '{36'h000000001, 7'd15, 0, 0, 2'b01, {3'b000, 16'h0004}, 0};
`else
      vt[8]  = '{36'h000000001, 7'd15, 0, 0, 2'b01, {3'b011, 16'h0000}, 0};
`endif
      vt[9]  = '{36'h000000000, 7'd3,  0, 0, 2'b01, {3'b000, 16'h0000}, 0};
      vt[10] = '{36'h000000000, 7'd3,  0, 0, 2'b10, {3'b000, 16'h8000}, 0};
      vt[11] = '{36'h000400000, 7'd20, 1, 0, 2'b00, {3'b000, 16'hD000}, 3};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_in_ready", 32'(in_ready), 32'd1);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_result", 32'(result), 32'h0000);
      chk("reset_flags", 32'(flags), 32'd0);
      @(posedge clk); #1 reset = 1'b0;

      foreach (vt[i]) begin
         chk($sformatf("model_pin%0d", i),
             32'(model(vt[i].m, int'($signed(vt[i].e)), vt[i].s, vt[i].st, vt[i].rm)),
             32'(vt[i].want));
         do_op(vt[i].m, vt[i].e, vt[i].s, vt[i].st, vt[i].rm, vt[i].stall, 1'b1, vt[i].want);
      end

      // Reset pulse while the operation sits in NORM.
      @(posedge clk); #1;
      sm = 36'h000400000; se = 7'd15; ss = 1'b0; sticky_in = 1'b0; roundmode = 2'b01;
      in_valid = 1'b1; out_ready = 1'b1;
      @(negedge clk);
      chk("rst_test_accept", 32'(in_ready), 32'd1);
      @(posedge clk); #1 in_valid = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      @(negedge clk);
      chk("midop_reset_out_valid", 32'(out_valid), 32'd0);
      chk("midop_reset_in_ready", 32'(in_ready), 32'd1);
      chk("midop_reset_result", 32'(result), 32'h0000);
      repeat (8) @(negedge clk);

      for (int k = 0; k < 300; k++) begin
         w = int'($urandom_range(0, 36));
         mm = {$urandom, $urandom};
         mm = (w == 0) ? 36'h0 : ((mm & ((one << w) - one)) | (one << (w - 1)));
         ee = 22 - (w - 1) + int'($urandom_range(0, 44)) - 10;
         if (w == 0) ee = int'($urandom_range(0, 127)) - 64;
         if (ee > 63) ee = 63;
         if (ee < -64) ee = -64;
         do_op(mm, 7'(ee), 1'($urandom), ($urandom_range(0, 3) == 0), 2'($urandom),
               ($urandom_range(0, 7) == 0) ? 6 : int'($urandom_range(0, 3)), 1'b0, 19'h0);
      end

      repeat (4) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
